// File: rtl/regfile_pkg.sv
// Shared widths, requester indices and the writeback request bundle
// for the regfile writeback arbiter.
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback handshake bundle: ALU (wb0) and LSU (wb1) requesters.
// master = requester side, slave = arbiter side.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic            wb0_valid;
  logic            wb0_ready;
  logic [AW-1:0]   wb0_addr;
  logic [XLEN-1:0] wb0_data;

  logic            wb1_valid;
  logic            wb1_ready;
  logic [AW-1:0]   wb1_addr;
  logic [XLEN-1:0] wb1_data;

  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    input  wb0_ready, wb1_ready
  );

  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    output wb0_ready, wb1_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when both
// requesters contend, so an uncontended requester never loses its turn.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr;

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= 1'b0;
    else if (req == 2'b11)
      ptr <= ~ptr;
  end

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant[ptr] = 1'b1;
      default:        grant      = req;
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and LSU writeback and
// tracks outstanding destination registers for RAW hazard detection.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_addr,
  output logic                 w_en,
  output logic [AW-1:0]        w_addr,
  output logic [XLEN-1:0]      w_data,
  output logic [NREG-1:0]      busy
);

  wb_req_t    req0;
  wb_req_t    req1;
  wb_req_t    sel;
  logic [1:0] req;
  logic [1:0] grant;
  logic       xfer;
  logic       wr;
  logic [NREG-1:0] busy_nxt;

  assign req0 = '{valid: wb.wb0_valid,
                  addr:  wb.wb0_addr,
                  data:  wb.wb0_data};
  assign req1 = '{valid: wb.wb1_valid,
                  addr:  wb.wb1_addr,
                  data:  wb.wb1_data};

  assign req = {req1.valid & ~reset,
                req0.valid & ~reset};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  assign wb.wb0_ready = grant[REQ_ALU];
  assign wb.wb1_ready = grant[REQ_LSU];

  assign sel  = grant[REQ_LSU] ? req1 : req0;
  assign xfer = |grant;
  assign wr   = xfer && (sel.addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      w_en   <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      w_en <= wr;
      if (wr) begin
        w_addr <= sel.addr;
        w_data <= sel.data;
      end
    end
  end

  // Set after clear: a re-issued producer must stay outstanding.
  always_comb begin
    busy_nxt = busy;
    if (xfer)
      busy_nxt[sel.addr] = 1'b0;
    if (issue_en)
      busy_nxt[issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a behavioural
// model of arbitration, write timing and the busy scoreboard.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;
  logic            w_en;
  logic [AW-1:0]   w_addr;
  logic [XLEN-1:0] w_data;
  logic [NREG-1:0] busy;

  regfile_wb_arbiter_if wbi ();

  regfile_wb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .wb         (wbi.slave),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .w_en       (w_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int              m_ptr;
  bit              m_wen;
  int              m_waddr;
  logic [XLEN-1:0] m_wdata;
  bit              m_busy [NREG];
  int              last_g;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_wen   = 0;
    m_waddr = 0;
    m_wdata = '0;
    foreach (m_busy[r]) m_busy[r] = 0;
  endtask

  // Compare at the falling edge, then advance the model to the
  // state expected after the next rising edge.
  task automatic tick();
    int              g;
    int              a;
    logic [XLEN-1:0] d;
    logic [NREG-1:0] bv;
    @(negedge clk);
    g = -1;
    if (!reset) begin
      if (wbi.wb0_valid && wbi.wb1_valid) g = m_ptr;
      else if (wbi.wb0_valid)             g = 0;
      else if (wbi.wb1_valid)             g = 1;
    end
    check("wb0_ready", wbi.wb0_ready, g == 0);
    check("wb1_ready", wbi.wb1_ready, g == 1);
    check("w_en", w_en, m_wen);
    check("w_addr", w_addr, m_waddr);
    check("w_data", w_data, m_wdata);
    for (int r = 0; r < NREG; r++) bv[r] = m_busy[r];
    check("busy", busy, bv);
    if (reset) begin
      model_reset();
    end else begin
      if (wbi.wb0_valid && wbi.wb1_valid) m_ptr = 1 - m_ptr;
      m_wen = 0;
      if (g >= 0) begin
        a = (g == 0) ? int'(wbi.wb0_addr) : int'(wbi.wb1_addr);
        d = (g == 0) ? wbi.wb0_data : wbi.wb1_data;
        m_busy[a] = 0;
        if (a != 0) begin
          m_wen   = 1;
          m_waddr = a;
          m_wdata = d;
        end
      end
      if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v0, int a0, logic [XLEN-1:0] d0,
                       bit v1, int a1, logic [XLEN-1:0] d1);
    wbi.wb0_valid = v0;
    wbi.wb0_addr  = AW'(a0);
    wbi.wb0_data  = d0;
    wbi.wb1_valid = v1;
    wbi.wb1_addr  = AW'(a1);
    wbi.wb1_data  = d1;
  endtask

  task automatic issue(bit en, int a);
    issue_en   = en;
    issue_addr = AW'(a);
  endtask

  initial begin
    reset = 1'b1;
    issue(0, 0);
    drive(1, 3, 32'h33, 1, 7, 32'h77);
    @(posedge clk);
    #1;
    model_reset();

    // reset held with both requesters valid
    repeat (4) tick();
    reset = 1'b0;

    // contention: grants alternate starting at ALU
    repeat (4) tick();

    // single ALU writeback
    drive(1, 5, 32'h0000_00A5, 0, 0, '0);
    tick();
    drive(0, 0, '0, 0, 0, '0);
    tick();

    // x0 writeback and x0 issue are dropped
    drive(0, 0, '0, 1, 0, 32'hDEAD_BEEF);
    tick();
    drive(0, 0, '0, 0, 0, '0);
    issue(1, 0);
    tick();
    issue(0, 0);
    tick();

    // scoreboard set/clear race on x9
    issue(1, 9);
    tick();
    issue(0, 0);
    tick();
    drive(1, 9, 32'h99, 0, 0, '0);
    issue(1, 9);
    tick();
    drive(0, 0, '0, 0, 0, '0);
    issue(0, 0);
    tick();
    drive(1, 9, 32'h999, 0, 0, '0);
    tick();
    drive(0, 0, '0, 0, 0, '0);
    tick();

    // reset right after a captured write; pointer returns to ALU
    drive(1, 3, 32'h33, 1, 7, 32'h77);
    tick();
    drive(1, 12, 32'hC0C0, 0, 0, '0);
    tick();
    reset = 1'b1;
    drive(0, 0, '0, 0, 0, '0);
    tick();
    reset = 1'b0;
    drive(1, 4, 32'h44, 1, 8, 32'h88);
    tick();
    tick();

    // randomized traffic, requesters hold while stalled
    for (int c = 0; c < 600; c++) begin
      if (!(wbi.wb0_valid && last_g != 0)) begin
        wbi.wb0_valid = ($urandom % 4) != 0;
        wbi.wb0_addr  = AW'($urandom_range(0, 12));
        wbi.wb0_data  = $urandom;
      end
      if (!(wbi.wb1_valid && last_g != 1)) begin
        wbi.wb1_valid = ($urandom % 3) != 0;
        wbi.wb1_addr  = AW'($urandom_range(0, 12));
        wbi.wb1_data  = $urandom;
      end
      issue(($urandom % 2) == 1, $urandom_range(0, 12));
      reset = ($urandom % 80) == 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single regfile write port (w_en/w_addr/w_data) between two writeback requesters: requester 0 is the execute/ALU unit and requester 1 is the load/store unit.
- Arbitration is round-robin over valid/ready handshakes.
- Outputs to the regfile are registered.
- A per-register busy scoreboard is set at instruction issue and cleared when the matching write commits, so decode can detect RAW hazards.
- Sits between the execute/LSU writeback stages and the regfile.

Parameters:
XLEN, 32, data width of regfile entries and writeback data
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
wb0_valid  in  1  requester 0 (ALU) has a writeback pending
wb0_ready  out  1  requester 0 writeback accepted this cycle
wb0_addr  in  AW  requester 0 destination register
wb0_data  in  XLEN  requester 0 write data
wb1_valid  in  1  requester 1 (LSU) has a writeback pending
wb1_ready  out  1  requester 1 writeback accepted this cycle
wb1_addr  in  AW  requester 1 destination register
wb1_data  in  XLEN  requester 1 write data
issue_en  in  1  an instruction with a destination register is issuing
issue_addr  in  AW  destination register of the issuing instruction
w_en  out  1  regfile write enable (registered)
w_addr  out  AW  regfile write address (registered)
w_data  out  XLEN  regfile write data (registered)
busy  out  NREG  scoreboard: bit r set means a write to register r is outstanding

Behaviour:
- Reset: w_en=0, w_addr=0, w_data=0, busy=0, and the round-robin pointer favours requester 0. While reset is high, wb0_ready=wb1_ready=0.
- Handshakes:
  - wbN_ready is combinational and equals grantN.
  - A transfer occurs on any cycle where wbN_valid && wbN_ready.
  - Requesters hold addr/data stable while valid is high and not ready.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted. The pointer then moves to the other requester. The pointer changes only on a contended grant.
  - Neither valid: no grant and the pointer holds.
- Write timing:
  - A transfer in cycle N produces w_en=1 with the captured addr/data in cycle N+1.
  - w_en=0 in any cycle that follows a cycle with no transfer.
  - Sustained throughput is one write per cycle.
- x0 handling: a transfer with addr=0 completes the handshake (ready=1) but w_en stays 0 in cycle N+1, and w_addr/w_data hold their previous values.
- Scoreboard:
  - busy[r] is set the cycle after issue_en with issue_addr=r, for r≠0.
  - busy[r] is cleared the cycle after a transfer to r.
  - issue_en with issue_addr=0 is ignored; busy[0] is always 0.
- Simultaneous set and clear of the same r in one cycle: set wins, because the newer producer stays outstanding.
- Set and clear of different registers in the same cycle both take effect.
- Both requesters are never granted in the same cycle. Two outstanding writes to the same register are allowed and the later commit wins in the regfile.
- Reset mid-operation: reset takes priority over everything. Any pending captured write is dropped (w_en=0 the next cycle), busy clears, and the pointer returns to requester 0.

Decomposition:
- Package regfile_pkg holds XLEN, NREG, AW, the requester index constants REQ_ALU=0 and REQ_LSU=1, and a wb_req_t struct {valid, addr, data}.
- Sub-module rr_arb2 is the 2-way round-robin arbiter: inputs req[1:0]; outputs grant[1:0], one-hot or zero; it holds the pointer state internally.
- The scoreboard and output register stay in the top module.

Test Plan:
- Reset: hold reset 4 cycles with both valids high -> ready=0, w_en=0, busy=0; on release with both valid, wb0 is granted first.
- Single requester: wb0_valid with addr=5, data=0x0000_00A5 for 1 cycle -> wb0_ready=1 in the same cycle; next cycle w_en=1, w_addr=5, w_data=0xA5.
- Contention: both valid for 4 cycles (wb0 addr=3 data=0x33, wb1 addr=7 data=0x77) -> grants alternate 0,1,0,1 and the w_addr sequence is 3,7,3,7 with no idle cycle.
- x0 drop: wb1_valid, addr=0, data=0xDEAD_BEEF -> wb1_ready=1; next cycle w_en=0 and w_data unchanged; issue_en with addr=0 leaves busy=0.
- Scoreboard set/clear race:
  - issue_en addr=9 -> busy[9]=1 next cycle.
  - Later, a wb0 transfer to 9 in the same cycle as issue_en addr=9 -> busy[9] stays 1.
  - A further transfer to 9 without issue -> busy[9]=0.
- Mid-operation reset: capture a wb0 transfer to addr=12 and assert reset in the following cycle -> w_en=0 the cycle after reset samples high, busy=0, and the pointer is back at requester 0.
